// File: rtl/surface_pos_pkg.sv
// Shared widths, divider length and FSM encoding for the logical-to-physical
// surface position converter.
package surface_pos_pkg;
  localparam int COORD_W    = 16;
  localparam int PAD_W      = 3;
  localparam int DIV_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHK  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } fsm_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CHK  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/surface_pos_logic_to_phy_if.sv
// Job request/result bundle of the surface position converter, plus the FSM
// state for observation.
interface surface_pos_logic_to_phy_if;
  import surface_pos_pkg::*;

  // Handshake: a job is accepted on a clock edge where aclken=1, blk_idle=1
  // and blk_start=1; blk_start is ignored at any other time. The result is
  // presented with a one-cycle blk_done pulse and then held until the next one.
  logic               blk_start;
  logic               blk_idle;
  logic [COORD_W-1:0] blk_i_logic_x;
  logic [COORD_W-1:0] blk_i_logic_y;
  logic               blk_i_en_x_cvt;
  logic               blk_i_en_y_cvt;
  logic               blk_done;
  logic [COORD_W-1:0] blk_o_phy_x;
  logic [COORD_W-1:0] blk_o_phy_y;
  logic               blk_o_is_vld;
  fsm_e               fsm_state;

  modport master (
    output blk_start, blk_i_logic_x, blk_i_logic_y, blk_i_en_x_cvt, blk_i_en_y_cvt,
    input  blk_idle, blk_done, blk_o_phy_x, blk_o_phy_y, blk_o_is_vld, fsm_state
  );

  modport slave (
    input  blk_start, blk_i_logic_x, blk_i_logic_y, blk_i_en_x_cvt, blk_i_en_y_cvt,
    output blk_idle, blk_done, blk_o_phy_x, blk_o_phy_y, blk_o_is_vld, fsm_state
  );
endinterface

// File: rtl/surface_pos_axis_cvt.sv
// One axis of the converter: range check, pad subtract, divide by (inner+1),
// then valid/physical selection. SURFACE_POS_FAST_DIV_EN selects a one-cycle divide.
module surface_pos_axis_cvt
  import surface_pos_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               chk,
  input  logic               div_step,
  input  logic               fin,
  input  logic [COORD_W-1:0] coord,
  input  logic               en_cvt,
  input  logic [COORD_W-1:0] limit,
  input  logic [PAD_W-1:0]   pad,
  input  logic [PAD_W-1:0]   inner,
  output logic [COORD_W-1:0] phy,
  output logic               vld
);

  logic [COORD_W-1:0] c_q;
  logic               cvt_q;
  logic               out_q;
  logic [COORD_W-1:0] q_q;
  logic [3:0]         r_q;
  logic [3:0]         divisor;
  logic [COORD_W-1:0] pad_ext;
  logic               valid;
  logic [COORD_W-1:0] q_next;
  logic [3:0]         r_next;

  assign divisor = {1'b0, inner} + 4'd1;
  assign pad_ext = {{(COORD_W-PAD_W){1'b0}}, pad};

`ifdef SURFACE_POS_FAST_DIV_EN
  // Reciprocal multiply: q = (d * m) >> s, constants exact over all 16-bit d.
  logic [16:0] recip_m;
  logic [4:0]  recip_s;
  logic [33:0] prod;

  always_comb begin
    recip_m = 17'd65536;
    recip_s = 5'd16;
    case (inner)
      3'd0: begin recip_m = 17'd65536; recip_s = 5'd16; end
      3'd1: begin recip_m = 17'd65536; recip_s = 5'd17; end
      3'd2: begin recip_m = 17'd43691; recip_s = 5'd17; end
      3'd3: begin recip_m = 17'd65536; recip_s = 5'd18; end
      3'd4: begin recip_m = 17'd52429; recip_s = 5'd18; end
      3'd5: begin recip_m = 17'd43691; recip_s = 5'd18; end
      3'd6: begin recip_m = 17'd74899; recip_s = 5'd19; end
      3'd7: begin recip_m = 17'd65536; recip_s = 5'd19; end
      default: ;
    endcase
  end

  assign prod   = {18'd0, q_q} * {17'd0, recip_m};
  assign q_next = 16'(prod >> recip_s);
  assign r_next = 4'(q_q - 16'(q_next * {12'd0, divisor}));
`else
  // Restoring radix-2 step: q_q holds the dividend and fills with quotient bits.
  logic [4:0] trial;
  logic       ge;

  assign trial  = {r_q, q_q[COORD_W-1]};
  assign ge     = trial >= {1'b0, divisor};
  assign r_next = ge ? 4'(trial - {1'b0, divisor}) : trial[3:0];
  assign q_next = {q_q[COORD_W-2:0], ge};
`endif

  assign valid = cvt_q ? (!out_q && r_q == 4'd0) : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q   <= '0;
      cvt_q <= 1'b0;
      out_q <= 1'b0;
      q_q   <= '0;
      r_q   <= '0;
      phy   <= '0;
      vld   <= 1'b0;
    end else begin
      if (load) begin
        c_q   <= coord;
        cvt_q <= en_cvt;
      end
      if (chk) begin
        out_q <= (c_q < pad_ext) || (c_q > limit);
        q_q   <= c_q - pad_ext;
        r_q   <= '0;
      end
      if (div_step) begin
        q_q <= q_next;
        r_q <= r_next;
      end
      if (fin) begin
        phy <= cvt_q ? (valid ? q_q : '0) : c_q;
        vld <= valid;
      end
    end
  end

endmodule

// File: rtl/surface_pos_logic_to_phy.sv
// Logical (padded/dilated) to physical feature-map position converter, one
// job at a time. SURFACE_POS_FAST_DIV_EN shortens DIV to a single cycle.
module surface_pos_logic_to_phy
  import surface_pos_pkg::*;
(
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               aclken,
  input  logic [COORD_W-1:0] ext_j_right,
  input  logic [COORD_W-1:0] ext_i_bottom,
  input  logic [PAD_W-1:0]   external_padding_left,
  input  logic [PAD_W-1:0]   external_padding_top,
  input  logic [PAD_W-1:0]   inner_padding_top_bottom,
  input  logic [PAD_W-1:0]   inner_padding_left_right,
  surface_pos_logic_to_phy_if.slave blk
);

  logic [1:0] state;
  logic       done_q;
  logic       load_stb;
  logic       chk_stb;
  logic       div_stb;
  logic       fin_stb;
  logic       div_last;
  logic       vld_x;
  logic       vld_y;

  assign load_stb = aclken && (state == ST_IDLE) && blk.blk_start;
  assign chk_stb  = aclken && (state == ST_CHK);
  assign div_stb  = aclken && (state == ST_DIV);
  assign fin_stb  = aclken && (state == ST_DONE);

`ifdef SURFACE_POS_FAST_DIV_EN
  assign div_last = 1'b1;
`else
  logic [3:0] cnt;

  assign div_last = (cnt == 4'(DIV_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (chk_stb) begin
      cnt <= '0;
    end else if (div_stb) begin
      cnt <= cnt + 4'd1;
    end
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
    end else if (aclken) begin
      done_q <= fin_stb;
      case (state)
        ST_IDLE: if (blk.blk_start) state <= ST_CHK;
        ST_CHK:  state <= ST_DIV;
        ST_DIV:  if (div_last) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  surface_pos_axis_cvt u_x (
    .clk      (aclk),
    .rst_n    (aresetn),
    .load     (load_stb),
    .chk      (chk_stb),
    .div_step (div_stb),
    .fin      (fin_stb),
    .coord    (blk.blk_i_logic_x),
    .en_cvt   (blk.blk_i_en_x_cvt),
    .limit    (ext_j_right),
    .pad      (external_padding_left),
    .inner    (inner_padding_left_right),
    .phy      (blk.blk_o_phy_x),
    .vld      (vld_x)
  );

  surface_pos_axis_cvt u_y (
    .clk      (aclk),
    .rst_n    (aresetn),
    .load     (load_stb),
    .chk      (chk_stb),
    .div_step (div_stb),
    .fin      (fin_stb),
    .coord    (blk.blk_i_logic_y),
    .en_cvt   (blk.blk_i_en_y_cvt),
    .limit    (ext_i_bottom),
    .pad      (external_padding_top),
    .inner    (inner_padding_top_bottom),
    .phy      (blk.blk_o_phy_y),
    .vld      (vld_y)
  );

  assign blk.blk_idle     = (state == ST_IDLE);
  assign blk.blk_done     = done_q;
  assign blk.blk_o_is_vld = vld_x & vld_y;
  assign blk.fsm_state    = fsm_e'(state);

endmodule

// File: tb/tb_surface_pos_logic_to_phy.sv
// Scoreboard bench for surface_pos_logic_to_phy on a 3x3 map with unit
// external and inner padding (7x7 logical grid).
module tb_surface_pos_logic_to_phy;
  import surface_pos_pkg::*;

  localparam int W   = 33;
  localparam int LAT = 18;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        aclken = 1'b1;
  logic [15:0] ext_j_right = 16'd5;
  logic [15:0] ext_i_bottom = 16'd5;
  logic [2:0]  external_padding_left = 3'd1;
  logic [2:0]  external_padding_top = 3'd1;
  logic [2:0]  inner_padding_top_bottom = 3'd1;
  logic [2:0]  inner_padding_left_right = 3'd1;

  surface_pos_logic_to_phy_if blk ();

  surface_pos_logic_to_phy dut (
    .aclk                     (aclk),
    .aresetn                  (aresetn),
    .aclken                   (aclken),
    .ext_j_right              (ext_j_right),
    .ext_i_bottom             (ext_i_bottom),
    .external_padding_left    (external_padding_left),
    .external_padding_top     (external_padding_top),
    .inner_padding_top_bottom (inner_padding_top_bottom),
    .inner_padding_left_right (inner_padding_left_right),
    .blk                      (blk)
  );

  // Clock / reset
  always #5 aclk = ~aclk;

  int unsigned cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int unsigned  lat_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Monitor: every done pulse consumes one expected result and its due cycle
  always @(negedge aclk) begin
    if (aresetn && blk.blk_done) begin : mon
      logic [W-1:0] got;
      logic [W-1:0] req;
      int unsigned  due;
      got = {blk.blk_o_phy_x, blk.blk_o_phy_y, blk.blk_o_is_vld};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=%h required=no_pulse", got);
      end else begin
        req = exp_q.pop_front();
        due = lat_q.pop_front();
        check("result", got, req);
        check("done_cycle", W'(cyc), W'(due));
      end
    end
  end

  // Driver: mode 0 plain, 1 extra start while busy, 2 aclken gap of 5 cycles
  task automatic run_job(input logic [15:0] x, input logic [15:0] y,
                         input logic enx, input logic eny,
                         input logic [15:0] px, input logic [15:0] py,
                         input logic v, input int mode);
    int unsigned c0;
    int          extra;
    for (int i = 0; i < 50 && !blk.blk_idle; i++) @(negedge aclk);
    @(negedge aclk);
    blk.blk_i_logic_x  = x;
    blk.blk_i_logic_y  = y;
    blk.blk_i_en_x_cvt = enx;
    blk.blk_i_en_y_cvt = eny;
    blk.blk_start      = 1'b1;
    @(posedge aclk);
    #1;
    c0 = cyc;
    blk.blk_start = 1'b0;
    extra = (mode == 2) ? 5 : 0;
    exp_q.push_back({px, py, v});
    lat_q.push_back(c0 + LAT + extra);
    if (mode == 1) begin
      repeat (4) @(negedge aclk);
      check("busy_idle", W'(blk.blk_idle), W'(0));
      blk.blk_i_logic_x = 16'd0;
      blk.blk_i_logic_y = 16'd0;
      blk.blk_start     = 1'b1;
      @(negedge aclk);
      blk.blk_start = 1'b0;
    end else if (mode == 2) begin
      repeat (4) @(negedge aclk);
      aclken = 1'b0;
      repeat (5) @(negedge aclk);
      aclken = 1'b1;
    end
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge aclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout got=pending required=done");
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge aclk);
    check("done_one_cycle", W'(blk.blk_done), W'(0));
  endtask

  initial begin
    int done_seen;
    blk.blk_start      = 1'b0;
    blk.blk_i_logic_x  = '0;
    blk.blk_i_logic_y  = '0;
    blk.blk_i_en_x_cvt = 1'b0;
    blk.blk_i_en_y_cvt = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_idle", W'(blk.blk_idle), W'(1));
    check("reset_done", W'(blk.blk_done), W'(0));
    check("reset_outputs", {blk.blk_o_phy_x, blk.blk_o_phy_y, blk.blk_o_is_vld}, '0);
    aresetn = 1'b1;
    @(negedge aclk);

    run_job(16'd0, 16'd0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 0);  // top pad
    run_job(16'd3, 16'd3, 1'b1, 1'b1, 16'd1, 16'd1, 1'b1, 0);
    run_job(16'd5, 16'd5, 1'b1, 1'b1, 16'd2, 16'd2, 1'b1, 0);  // last real pixel
    run_job(16'd2, 16'd1, 1'b0, 1'b1, 16'd2, 16'd0, 1'b1, 0);
    run_job(16'd4, 16'd2, 1'b1, 1'b1, 16'd0, 16'd0, 1'b0, 0);  // inner pad
    run_job(16'd6, 16'd6, 1'b1, 1'b1, 16'd0, 16'd0, 1'b0, 0);  // beyond edge
    run_job(16'd1, 16'd1, 1'b1, 1'b1, 16'd0, 16'd0, 1'b1, 0);  // first real pixel
    run_job(16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hABCD, 16'h1234, 1'b1, 0);
    run_job(16'd5, 16'd3, 1'b1, 1'b1, 16'd2, 16'd1, 1'b1, 1);  // start while busy
    run_job(16'd3, 16'd5, 1'b1, 1'b1, 16'd1, 16'd2, 1'b1, 2);  // aclken gap

    // Reset in the middle of DIV aborts the job
    @(negedge aclk);
    blk.blk_i_logic_x  = 16'd3;
    blk.blk_i_logic_y  = 16'd3;
    blk.blk_i_en_x_cvt = 1'b1;
    blk.blk_i_en_y_cvt = 1'b1;
    blk.blk_start      = 1'b1;
    @(negedge aclk);
    blk.blk_start = 1'b0;
    repeat (8) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("abort_idle", W'(blk.blk_idle), W'(1));
    check("abort_outputs", {blk.blk_o_phy_x, blk.blk_o_phy_y, blk.blk_o_is_vld}, '0);
    @(negedge aclk);
    aresetn = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge aclk);
      if (blk.blk_done) done_seen++;
    end
    check("abort_no_done", W'(done_seen), W'(0));

    run_job(16'd5, 16'd3, 1'b1, 1'b1, 16'd2, 16'd1, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
